// File: rtl/switch_conditioner_if.sv
// Switch conditioner bus: raw switches and consumer strobe in, conditioned levels and presses out.
interface switch_conditioner_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] sw;
    logic             tick;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] press;
    logic             multi;

    // Consumer side: drives switches and tick, observes conditioned outputs.
    modport master (
        output sw,
        output tick,
        input  clean,
        input  rise,
        input  press,
        input  multi
    );

    // Conditioner side.
    modport slave (
        input  sw,
        input  tick,
        output clean,
        output rise,
        output press,
        output multi
    );
endinterface

// File: rtl/switch_conditioner.sv
// Slide-switch front end: 2-flop synchroniser, per-channel debounce FSM,
// rise pulse, sticky press latch held until the consumer's tick, multi-press flag.
module switch_conditioner #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    switch_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // BLOCK guards against a switch that is already on at reset: it must be
    // seen off for a full window before any press can be generated.
    typedef enum logic [1:0] {
        BLOCK = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2
    } state_t;

    state_t           state [WIDTH];
    logic [CNT_W-1:0] cnt   [WIDTH];

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] press_next;
    logic             multi_q;
    logic             multi_next;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.sw;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce FSM; a level is accepted after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                state[i] <= BLOCK;
                cnt[i]   <= '0;
            end
            clean_q <= '0;
            rise_q  <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                rise_q[i] <= 1'b0;
                case (state[i])
                    BLOCK: begin
                        clean_q[i] <= 1'b0;
                        if (sync2[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i] <= LOW;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    LOW: begin
                        clean_q[i] <= 1'b0;
                        if (!sync2[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i]   <= HIGH;
                            cnt[i]     <= '0;
                            clean_q[i] <= 1'b1;
                            rise_q[i]  <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        clean_q[i] <= 1'b1;
                        if (sync2[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i]   <= LOW;
                            cnt[i]     <= '0;
                            clean_q[i] <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[i]   <= BLOCK;
                        cnt[i]     <= '0;
                        clean_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Next press vector: a new rise wins over a coincident tick; multi counts it.
    always_comb begin
        int unsigned pop;
        press_next = rise_q | (press_q & ~{WIDTH{bus.tick}});
        pop        = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop = pop + 32'(press_next[i]);
        end
        multi_next = (pop >= 32'd2);
    end

    // Sticky press latch and multi-press flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            press_q <= '0;
            multi_q <= 1'b0;
        end else begin
            press_q <= press_next;
            multi_q <= multi_next;
        end
    end

    assign bus.clean = clean_q;
    assign bus.rise  = rise_q;
    assign bus.press = press_q;
    assign bus.multi = multi_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DEBOUNCE_CYCLES=4, WIDTH=4.
module tb_switch_conditioner;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    switch_conditioner_if #(.WIDTH(4)) bus ();

    switch_conditioner #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.sw   = 4'b0000;
        bus.tick = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_clean", bus.clean, 4'b0000);
        check("rst_rise",  bus.rise,  4'b0000);
        check("rst_press", bus.press, 4'b0000);
        check("rst_multi", {3'b000, bus.multi}, 4'b0000);
        reset = 1'b0;

        // Test 1: single press on channel 2 after BLOCK->LOW.
        repeat (6) @(negedge clock);
        check("t1_idle", bus.clean, 4'b0000);
        bus.sw = 4'b0100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            check("t1_clean", bus.clean, (k >= 6) ? 4'b0100 : 4'b0000);
            check("t1_rise",  bus.rise,  (k == 6) ? 4'b0100 : 4'b0000);
            check("t1_press", bus.press, (k >= 7) ? 4'b0100 : 4'b0000);
        end
        repeat (3) begin
            @(negedge clock);
            check("t1_hold", bus.press, 4'b0100);
        end
        bus.tick = 1'b1;
        @(negedge clock);
        check("t1_tick", bus.press, 4'b0000);
        check("t1_multi", {3'b000, bus.multi}, 4'b0000);
        @(negedge clock);
        bus.tick = 1'b0;
        check("t1_tick2", bus.press, 4'b0000);

        // Test 2: channel 0 bounces every 2 cycles, then settles high.
        for (int seg = 0; seg < 6; seg++) begin
            bus.sw = (seg % 2 == 0) ? 4'b0101 : 4'b0100;
            repeat (2) begin
                @(negedge clock);
                check("t2_bounce_clean", bus.clean, 4'b0100);
                check("t2_bounce_rise",  bus.rise,  4'b0000);
            end
        end
        bus.sw = 4'b0101;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            check("t2_clean", bus.clean, (k >= 6) ? 4'b0101 : 4'b0100);
            check("t2_rise",  bus.rise,  (k == 6) ? 4'b0001 : 4'b0000);
            check("t2_press", bus.press, (k >= 7) ? 4'b0001 : 4'b0000);
        end
        check("t2_multi", {3'b000, bus.multi}, 4'b0000);

        // Test 3: switch on through reset never presses until seen off.
        #2 reset = 1'b1;
        bus.sw = 4'b0010;
        #1;
        check("t3_async_clean", bus.clean, 4'b0000);
        check("t3_async_press", bus.press, 4'b0000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            check("t3_blk_clean", bus.clean, 4'b0000);
            check("t3_blk_rise",  bus.rise,  4'b0000);
            check("t3_blk_press", bus.press, 4'b0000);
        end
        bus.sw = 4'b0000;
        repeat (6) begin
            @(negedge clock);
            check("t3_off_clean", bus.clean, 4'b0000);
        end
        bus.sw = 4'b0010;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            check("t3_clean", bus.clean, (k >= 6) ? 4'b0010 : 4'b0000);
            check("t3_rise",  bus.rise,  (k == 6) ? 4'b0010 : 4'b0000);
            check("t3_press", bus.press, (k >= 7) ? 4'b0010 : 4'b0000);
        end
        bus.tick = 1'b1;
        @(negedge clock);
        bus.tick = 1'b0;
        check("t3_tick", bus.press, 4'b0000);

        // Test 4: rise on channel 3 coincides with tick while channel 0 is pending.
        bus.sw = 4'b0011;
        repeat (7) @(negedge clock);
        check("t4_pending", bus.press, 4'b0001);
        bus.sw = 4'b1011;
        repeat (6) @(negedge clock);
        check("t4_rise", bus.rise, 4'b1000);
        bus.tick = 1'b1;
        @(negedge clock);
        bus.tick = 1'b0;
        check("t4_set_wins", bus.press, 4'b1000);
        check("t4_multi", {3'b000, bus.multi}, 4'b0000);
        @(negedge clock);
        check("t4_hold", bus.press, 4'b1000);
        bus.tick = 1'b1;
        @(negedge clock);
        bus.tick = 1'b0;
        check("t4_clear", bus.press, 4'b0000);

        // Test 5: simultaneous presses raise multi until tick.
        bus.sw = 4'b0000;
        repeat (8) @(negedge clock);
        check("t5_idle", bus.clean, 4'b0000);
        bus.sw = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            check("t5_clean", bus.clean, (k >= 6) ? 4'b0101 : 4'b0000);
            check("t5_rise",  bus.rise,  (k == 6) ? 4'b0101 : 4'b0000);
            check("t5_press", bus.press, (k >= 7) ? 4'b0101 : 4'b0000);
            check("t5_multi", {3'b000, bus.multi}, (k >= 7) ? 4'b0001 : 4'b0000);
        end
        bus.tick = 1'b1;
        @(negedge clock);
        bus.tick = 1'b0;
        check("t5_tick_press", bus.press, 4'b0000);
        check("t5_tick_multi", {3'b000, bus.multi}, 4'b0000);

        // Test 6: reset mid-window on channel 2 discards the partial window.
        bus.sw = 4'b0001;
        repeat (8) @(negedge clock);
        check("t6_pre_clean", bus.clean, 4'b0001);
        bus.sw = 4'b0101;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t6_async_clean", bus.clean, 4'b0000);
        check("t6_async_rise",  bus.rise,  4'b0000);
        check("t6_async_press", bus.press, 4'b0000);
        check("t6_async_multi", {3'b000, bus.multi}, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            check("t6_clean", bus.clean, 4'b0000);
            check("t6_rise",  bus.rise,  4'b0000);
            check("t6_press", bus.press, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
